// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolver.
// Holds the funct3 condition codes, the comparator mode (BrUn) encodings
// and the resolver state enum. It is imported by branch_cond and
// branch_resolve.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] BRUN_OFF = 2'b00;
  localparam logic [1:0] BRUN_U   = 2'b01;
  localparam logic [1:0] BRUN_S   = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator.
// Maps funct3 and the comparator flags to a comparator mode and a taken bit.
// It holds no state, so a future branch predictor can reuse it.
// Ports:
//   is_jump - unconditional jump: always taken, comparator unused
//   funct3  - branch condition code
//   br_eq   - equal flag from the comparator
//   br_lt   - less-than flag from the comparator
//   brun    - comparator mode for this funct3 (00 off, 01 unsigned, 11 signed)
//   taken   - branch/jump decision
module branch_cond
  import branch_pkg::*;
(
  input  logic       is_jump,
  input  logic [2:0] funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  output logic [1:0] brun,
  output logic       taken
);

  always_comb begin
    brun  = BRUN_OFF;
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  begin brun = BRUN_S; taken = br_eq;  end
      F3_BNE:  begin brun = BRUN_S; taken = !br_eq; end
      F3_BLT:  begin brun = BRUN_S; taken = br_lt;  end
      F3_BGE:  begin brun = BRUN_S; taken = !br_lt; end
      F3_BLTU: begin brun = BRUN_U; taken = br_lt;  end
      F3_BGEU: begin brun = BRUN_U; taken = !br_lt; end
      default: ;  // 010/011 are illegal and resolve as not taken
    endcase
    if (is_jump) begin
      brun  = BRUN_OFF;
      taken = 1'b1;
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolver between the execute-stage comparator and fetch.
// It turns a branch or jump into a taken/not-taken decision. A taken,
// word-aligned target becomes a registered PC redirect with a valid/ready
// handshake. Once fetch accepts the redirect, a pipeline flush is held for
// FLUSH_CYCLES cycles.
// Optional feature: define BRANCH_STATS_EN to add saturating counters for
// accepted and taken branches. Without the macro, the stat ports are tied
// to 0.
// Ports:
//   clk, rst_n       - clock (rising edge), asynchronous active-low reset
//   br_valid/ready   - branch handshake (ready only in IDLE)
//   br_is_jump       - unconditional jump
//   br_funct3        - branch condition code
//   br_target        - computed target address
//   BrEq, BrLt       - comparator flags
//   BrUn             - comparator mode select
//   redirect_valid/ready, redirect_pc - PC redirect to fetch
//   flush            - squash younger pipeline stages
//   misalign_exc     - one-cycle pulse for a taken, misaligned target
//   stat_branches, stat_taken - branch statistics
//
// state    | meaning
// IDLE     | accepting branches
// REDIRECT | redirect presented, waiting for redirect_ready
// FLUSH    | flush held while the counter runs down
module branch_resolve
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic            br_is_jump,
  input  logic [2:0]      br_funct3,
  input  logic [XLEN-1:0] br_target,
  input  logic            BrEq,
  input  logic            BrLt,
  output logic [1:0]      BrUn,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            misalign_exc,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              rv_n, flush_n, mis_n;
  logic [XLEN-1:0]   pc_n;
  logic [1:0]        cond_brun;
  logic              taken;
  logic              accept;

  branch_cond u_cond (
    .is_jump (br_is_jump),
    .funct3  (br_funct3),
    .br_eq   (BrEq),
    .br_lt   (BrLt),
    .brun    (cond_brun),
    .taken   (taken)
  );

  assign br_ready = (state == IDLE);
  assign accept   = br_valid && br_ready;
  assign BrUn     = (br_valid && !br_is_jump && state == IDLE) ? cond_brun : BRUN_OFF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      misalign_exc   <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      redirect_valid <= rv_n;
      redirect_pc    <= pc_n;
      flush          <= flush_n;
      misalign_exc   <= mis_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rv_n    = redirect_valid;
    pc_n    = redirect_pc;
    flush_n = flush;
    mis_n   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && taken) begin
          if (br_target[1:0] != 2'b00) begin
            mis_n = 1'b1;
          end else begin
            rv_n    = 1'b1;
            pc_n    = br_target;
            state_n = REDIRECT;
          end
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          rv_n = 1'b0;
          if (FLUSH_CYCLES > 0) begin
            state_n = FLUSH;
            cnt_n   = CW'(FLUSH_CYCLES - 1);
            flush_n = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      FLUSH: begin
        if (cnt == '0) begin
          flush_n = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= '0;
      stat_taken    <= '0;
    end else if (accept) begin
      if (stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
      if (taken && stat_taken != 32'hFFFF_FFFF) stat_taken <= stat_taken + 32'd1;
    end
  end
`else
  assign stat_branches = '0;
  assign stat_taken    = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid, br_ready, br_is_jump;
  logic [2:0]  br_funct3;
  logic [31:0] br_target;
  logic        BrEq, BrLt;
  logic [1:0]  BrUn;
  logic        redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
  logic        flush, misalign_exc;
  logic [31:0] stat_branches, stat_taken;

  int n_cmp = 0;
  int n_mis = 0;
  int nb = 0;
  int nt = 0;

  branch_resolve #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_is_jump     (br_is_jump),
    .br_funct3      (br_funct3),
    .br_target      (br_target),
    .BrEq           (BrEq),
    .BrLt           (BrLt),
    .BrUn           (BrUn),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .misalign_exc   (misalign_exc),
    .stat_branches  (stat_branches),
    .stat_taken     (stat_taken)
  );

  always #5 clk = ~clk;

  // outcome: 0 not taken, 1 aligned redirect, 2 misaligned
  typedef struct {
    logic        jump;
    logic [2:0]  f3;
    logic        eq;
    logic        lt;
    logic [31:0] tgt;
    logic [1:0]  brun;
    int          outcome;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string name);
`ifdef BRANCH_STATS_EN
    check({name, "_branches"}, stat_branches, nb);
    check({name, "_taken"}, stat_taken, nt);
`else
    check({name, "_branches"}, stat_branches, 32'd0);
    check({name, "_taken"}, stat_taken, 32'd0);
`endif
  endtask

  // Walks the handshake (redirect_ready already high) and the 2-cycle flush.
  task automatic walk_flush(input string name);
    tick;
    check({name, "_rv_drop"}, {31'd0, redirect_valid}, 32'd0);
    check({name, "_flush1"}, {31'd0, flush}, 32'd1);
    check({name, "_rdy_f1"}, {31'd0, br_ready}, 32'd0);
    tick;
    check({name, "_flush2"}, {31'd0, flush}, 32'd1);
    tick;
    check({name, "_flush_end"}, {31'd0, flush}, 32'd0);
    check({name, "_rdy_back"}, {31'd0, br_ready}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 3'b000, 1'b1, 1'b0, 32'h100, 2'b11, 1};
    vecs[1]  = '{1'b0, 3'b001, 1'b1, 1'b0, 32'h104, 2'b11, 0};
    vecs[2]  = '{1'b0, 3'b001, 1'b0, 1'b0, 32'h204, 2'b11, 1};
    vecs[3]  = '{1'b0, 3'b100, 1'b0, 1'b1, 32'h300, 2'b11, 1};
    vecs[4]  = '{1'b0, 3'b101, 1'b0, 1'b1, 32'h304, 2'b11, 0};
    vecs[5]  = '{1'b0, 3'b101, 1'b0, 1'b0, 32'h400, 2'b11, 1};
    vecs[6]  = '{1'b0, 3'b110, 1'b0, 1'b0, 32'h404, 2'b01, 0};
    vecs[7]  = '{1'b0, 3'b110, 1'b0, 1'b1, 32'h500, 2'b01, 1};
    vecs[8]  = '{1'b0, 3'b111, 1'b0, 1'b1, 32'h504, 2'b01, 0};
    vecs[9]  = '{1'b0, 3'b111, 1'b0, 1'b0, 32'h600, 2'b01, 1};
    vecs[10] = '{1'b0, 3'b010, 1'b1, 1'b1, 32'h604, 2'b00, 0};
    vecs[11] = '{1'b0, 3'b011, 1'b1, 1'b1, 32'h608, 2'b00, 0};
    vecs[12] = '{1'b1, 3'b000, 1'b0, 1'b0, 32'h202, 2'b00, 2};
    vecs[13] = '{1'b1, 3'b000, 1'b0, 1'b0, 32'h700, 2'b00, 1};
    vecs[14] = '{1'b0, 3'b000, 1'b1, 1'b0, 32'h103, 2'b11, 2};
    vecs[15] = '{1'b0, 3'b001, 1'b0, 1'b0, 32'h10, 2'b11, 1};

    rst_n = 1'b0;
    br_valid = 1'b0; br_is_jump = 1'b0; br_funct3 = 3'b000; br_target = '0;
    BrEq = 1'b0; BrLt = 1'b0; redirect_ready = 1'b0;
    #3;
    check("rst_rv", {31'd0, redirect_valid}, 32'd0);
    check("rst_pc", redirect_pc, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_mis", {31'd0, misalign_exc}, 32'd0);
    check("rst_ready", {31'd0, br_ready}, 32'd1);
    check_stats("rst");
    tick;
    rst_n = 1'b1;
    tick;
    check("idle_brun", {30'd0, BrUn}, 32'd0);

    redirect_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      br_valid = 1'b1;
      br_is_jump = vecs[i].jump; br_funct3 = vecs[i].f3;
      BrEq = vecs[i].eq; BrLt = vecs[i].lt; br_target = vecs[i].tgt;
      #1;
      check($sformatf("v%0d_brun", i), {30'd0, BrUn}, {30'd0, vecs[i].brun});
      check($sformatf("v%0d_ready", i), {31'd0, br_ready}, 32'd1);
      tick;
      br_valid = 1'b0;
      nb++;
      if (vecs[i].outcome != 0) nt++;
      check_stats($sformatf("v%0d_stat", i));
      case (vecs[i].outcome)
        1: begin
          check($sformatf("v%0d_rv", i), {31'd0, redirect_valid}, 32'd1);
          check($sformatf("v%0d_pc", i), redirect_pc, vecs[i].tgt);
          check($sformatf("v%0d_noflush", i), {31'd0, flush}, 32'd0);
          walk_flush($sformatf("v%0d", i));
        end
        2: begin
          check($sformatf("v%0d_mis", i), {31'd0, misalign_exc}, 32'd1);
          check($sformatf("v%0d_rv", i), {31'd0, redirect_valid}, 32'd0);
          check($sformatf("v%0d_ready_m", i), {31'd0, br_ready}, 32'd1);
          tick;
          check($sformatf("v%0d_mis_end", i), {31'd0, misalign_exc}, 32'd0);
        end
        default: begin
          check($sformatf("v%0d_rv", i), {31'd0, redirect_valid}, 32'd0);
          check($sformatf("v%0d_mis", i), {31'd0, misalign_exc}, 32'd0);
          check($sformatf("v%0d_ready_n", i), {31'd0, br_ready}, 32'd1);
        end
      endcase
    end

    // back-to-back: bltu not taken, bge not taken, bge taken
    br_valid = 1'b1; br_is_jump = 1'b0;
    br_funct3 = 3'b110; BrEq = 1'b0; BrLt = 1'b0; br_target = 32'h900;
    #1;
    check("b2b_bltu_brun", {30'd0, BrUn}, 32'd1);
    tick;
    nb++;
    br_funct3 = 3'b101; BrLt = 1'b1; br_target = 32'h904;
    #1;
    check("b2b_bge1_ready", {31'd0, br_ready}, 32'd1);
    check("b2b_bge1_brun", {30'd0, BrUn}, 32'd3);
    check("b2b_bge1_rv", {31'd0, redirect_valid}, 32'd0);
    tick;
    nb++;
    BrLt = 1'b0; br_target = 32'hA00;
    #1;
    check("b2b_bge2_ready", {31'd0, br_ready}, 32'd1);
    check("b2b_bge2_brun", {30'd0, BrUn}, 32'd3);
    tick;
    nb++; nt++;
    br_valid = 1'b0;
    check("b2b_rv", {31'd0, redirect_valid}, 32'd1);
    check("b2b_pc", redirect_pc, 32'hA00);
    walk_flush("b2b");
    check_stats("b2b_stat");

    // redirect_ready outside REDIRECT has no effect
    tick;
    check("idle_rr_rv", {31'd0, redirect_valid}, 32'd0);
    check("idle_rr_flush", {31'd0, flush}, 32'd0);
    check("idle_rr_ready", {31'd0, br_ready}, 32'd1);

    // fetch stalls the redirect for 5 cycles
    redirect_ready = 1'b0;
    br_valid = 1'b1; br_is_jump = 1'b0; br_funct3 = 3'b000;
    BrEq = 1'b1; br_target = 32'h800;
    tick;
    nb++; nt++;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        br_valid = 1'b1;
        #1;
        check("stall_brun_off", {30'd0, BrUn}, 32'd0);
        br_valid = 1'b0;
      end
      check($sformatf("stall%0d_rv", i), {31'd0, redirect_valid}, 32'd1);
      check($sformatf("stall%0d_pc", i), redirect_pc, 32'h800);
      check($sformatf("stall%0d_flush", i), {31'd0, flush}, 32'd0);
      check($sformatf("stall%0d_ready", i), {31'd0, br_ready}, 32'd0);
      tick;
    end
    check_stats("stall_stat");
    redirect_ready = 1'b1;
    check("stall_hs_rv", {31'd0, redirect_valid}, 32'd1);
    walk_flush("stall");
    redirect_ready = 1'b0;

    // reset asserted mid-FLUSH
    redirect_ready = 1'b1;
    br_valid = 1'b1; br_is_jump = 1'b1; br_target = 32'hC00;
    tick;
    br_valid = 1'b0;
    nb++; nt++;
    check("rf_rv", {31'd0, redirect_valid}, 32'd1);
    tick;
    check("rf_in_flush", {31'd0, flush}, 32'd1);
    #2;
    rst_n = 1'b0;
    nb = 0; nt = 0;
    #1;
    check("rf_flush", {31'd0, flush}, 32'd0);
    check("rf_ready", {31'd0, br_ready}, 32'd1);
    check("rf_rv0", {31'd0, redirect_valid}, 32'd0);
    check("rf_pc0", redirect_pc, 32'd0);
    check_stats("rf_stat");
    tick;
    rst_n = 1'b1;
    tick;
    check("rf_after_ready", {31'd0, br_ready}, 32'd1);
    check("rf_after_flush", {31'd0, flush}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
